// File: rtl/fb_triple_sched_if.sv
// rtl/fb_triple_sched_if.sv - frame-start, DMA handshake and buffer-select bundle
// The slave side is the scheduler, and the master side is the DMA and frame-sync environment.
interface fb_triple_sched_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              en_i;
  logic              fs_wr_i;
  logic              fs_rd_i;
  logic              wr_done_i;
  logic              rd_done_i;
  logic              wr_start_o;
  logic              wr_abort_o;
  logic [1:0]        wr_buf_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              rd_start_o;
  logic [1:0]        rd_buf_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              rd_new_o;
  logic [7:0]        drop_cnt_o;
  logic [7:0]        skip_cnt_o;

  modport master (
    output en_i, fs_wr_i, fs_rd_i, wr_done_i, rd_done_i,
    input  wr_start_o, wr_abort_o, wr_buf_o, wr_addr_o,
    input  rd_start_o, rd_buf_o, rd_addr_o, rd_new_o, drop_cnt_o, skip_cnt_o
  );

  modport slave (
    input  en_i, fs_wr_i, fs_rd_i, wr_done_i, rd_done_i,
    output wr_start_o, wr_abort_o, wr_buf_o, wr_addr_o,
    output rd_start_o, rd_buf_o, rd_addr_o, rd_new_o, drop_cnt_o, skip_cnt_o
  );
endinterface

// File: rtl/fb_triple_sched.sv
// rtl/fb_triple_sched.sv - triple-buffer frame scheduler for the write and read DMA engines
// The writer never targets the buffer being read, and the reader always takes the newest completed frame.
module fb_triple_sched #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 32'h0020_0000,
  parameter int unsigned       TO_W        = 24,
  parameter logic [TO_W-1:0]   TO_CYCLES   = 24'hFF_FFFF
) (
  input logic              clk_i,
  input logic              rst_i,
  fb_triple_sched_if.slave bus
);

  typedef enum logic [1:0] {W_IDLE, W_ARM, W_BUSY} w_state_t;
  typedef enum logic {R_IDLE, R_BUSY} r_state_t;

  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_LAST = TO_CYCLES - TO_ONE;

  w_state_t          w_state;
  r_state_t          r_state;
  logic [1:0]        wr_buf, rd_buf, last_done;
  logic              done_valid;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [TO_W-1:0]   wdog;
  logic              wr_start, wr_abort, rd_start, rd_new, reissue;
  logic [7:0]        drop_cnt, skip_cnt;

  logic       done_now, dv_n, rd_free, rd_take, wr_go, overrun, timeout;
  logic [1:0] ld_n, rd_buf_n, free_buf;

  function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] n);
    return BASE_ADDR + ADDR_W'(n) * FRAME_BYTES;
  endfunction

  function automatic logic [1:0] pick_free(input logic [1:0] rd, input logic [1:0] ld,
                                           input logic dv);
    logic [1:0] f;
    f = 2'd2;
    for (int i = 2; i >= 0; i--) begin
      if (2'(i) != rd && !(dv && 2'(i) == ld)) f = 2'(i);
    end
    return f;
  endfunction

  // Ordering within a cycle: a write completion is seen first, then the reader choice, then the writer choice.
  always_comb begin
    done_now = (w_state == W_BUSY) && bus.wr_done_i;
    ld_n     = done_now ? wr_buf : last_done;
    dv_n     = done_now || done_valid;
    rd_free  = (r_state == R_IDLE) || bus.rd_done_i;
    rd_take  = bus.fs_rd_i && rd_free && dv_n;
    rd_buf_n = rd_take ? ld_n : rd_buf;
    free_buf = pick_free(rd_buf_n, ld_n, dv_n);
    wr_go    = bus.fs_wr_i && bus.en_i && ((w_state == W_ARM) || done_now);
    overrun  = (w_state == W_BUSY) && !bus.wr_done_i && bus.fs_wr_i;
    timeout  = (w_state == W_BUSY) && !bus.wr_done_i && !bus.fs_wr_i && (wdog == TO_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      wr_buf     <= 2'd1;
      rd_buf     <= 2'd0;
      wr_addr    <= base_of(2'd1);
      rd_addr    <= base_of(2'd0);
      last_done  <= 2'd0;
      done_valid <= 1'b0;
      wdog       <= '0;
      wr_start   <= 1'b0;
      wr_abort   <= 1'b0;
      rd_start   <= 1'b0;
      rd_new     <= 1'b0;
      reissue    <= 1'b0;
      drop_cnt   <= 8'd0;
      skip_cnt   <= 8'd0;
    end else begin
      wr_start <= reissue;
      wr_abort <= 1'b0;
      rd_start <= 1'b0;
      reissue  <= 1'b0;

      if (done_now) begin
        last_done  <= wr_buf;
        done_valid <= 1'b1;
      end

      if (rd_take) begin
        rd_buf   <= rd_buf_n;
        rd_addr  <= base_of(rd_buf_n);
        rd_new   <= (rd_buf_n != rd_buf);
        rd_start <= 1'b1;
        r_state  <= R_BUSY;
      end else if (bus.fs_rd_i && !rd_free) begin
        if (skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
      end else if (bus.rd_done_i) begin
        r_state <= R_IDLE;
      end

      if (overrun || timeout) begin
        wr_abort <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      if (wr_go) begin
        wr_buf   <= free_buf;
        wr_addr  <= base_of(free_buf);
        wr_start <= 1'b1;
        wdog     <= '0;
        w_state  <= W_BUSY;
      end else begin
        case (w_state)
          W_IDLE: if (bus.en_i) w_state <= W_ARM;
          W_ARM:  if (!bus.en_i) w_state <= W_IDLE;
          W_BUSY: begin
            if (done_now || timeout) begin
              w_state <= W_ARM;
            end else if (overrun) begin
              // The aborted frame restarts on the same buffer one cycle after the abort.
              reissue <= 1'b1;
              wdog    <= '0;
            end else begin
              wdog <= wdog + TO_ONE;
            end
          end
          default: w_state <= W_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_start_o = wr_start;
  assign bus.wr_abort_o = wr_abort;
  assign bus.wr_buf_o   = wr_buf;
  assign bus.wr_addr_o  = wr_addr;
  assign bus.rd_start_o = rd_start;
  assign bus.rd_buf_o   = rd_buf;
  assign bus.rd_addr_o  = rd_addr;
  assign bus.rd_new_o   = rd_new;
  assign bus.drop_cnt_o = drop_cnt;
  assign bus.skip_cnt_o = skip_cnt;

endmodule
